// File: rtl/battle_pkg.sv
// Shared types and constants for the battle tick sequencer and its lane stepper.
package battle_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BF_START,
    BF_WAIT,
    BF_ACK,
    DAMAGE,
    MOVE,
    DONE
  } state_e;

  localparam int unsigned LOC_W        = 9;
  localparam int unsigned TYPE_W       = 2;
  localparam int unsigned IDX_W        = 4;
  localparam int unsigned N_SLOTS      = 16;
  localparam int unsigned LOC_MAX      = 511;
  localparam int unsigned SEL_NONE_BIT = 4;

  localparam logic [TYPE_W-1:0] TYPE_EMPTY = '0;

endpackage

// File: rtl/battle_tick_sequencer_lane_step.sv
// Combinational lane move calculator: one unit slot, returns write enable and new location.
module lane_step
  import battle_pkg::*;
#(
  parameter int unsigned STEP = 1
) (
  input  logic              side_i,
  input  logic [LOC_W-1:0]  loc_i,
  input  logic [TYPE_W-1:0] type_i,
  input  logic [LOC_W-1:0]  front_i,
  output logic              we_o,
  output logic [LOC_W-1:0]  new_loc_o
);

  localparam logic [LOC_W:0] STEP_X = STEP[LOC_W:0];
  localparam logic [LOC_W:0] MAX_X  = LOC_MAX[LOC_W:0];

  logic [LOC_W:0] loc_x;
  logic [LOC_W:0] front_x;
  logic [LOC_W:0] n;

  // One extra bit so friendly underflow and enemy overflow past LOC_MAX stay visible.
  always_comb begin
    loc_x   = {1'b0, loc_i};
    front_x = {1'b0, front_i};
    n       = side_i ? (loc_x + STEP_X) : (loc_x - STEP_X);
    we_o    = 1'b0;
    if (type_i != TYPE_EMPTY) begin
      if (side_i) begin
        we_o = (n <= MAX_X) && (n < front_x);
      end else begin
        we_o = (loc_x >= STEP_X) && (n > front_x);
      end
    end
    new_loc_o = n[LOC_W-1:0];
  end

endmodule

// File: rtl/battle_tick_sequencer.sv
// Per-tick controller: engine handshake, damage strobes, then a 32-slot lane move pass.
// Optional TICK_OVERRUN_CNT_EN adds a saturating overrun counter port.
module battle_tick_sequencer
  import battle_pkg::*;
#(
  parameter int unsigned STEP = 1,
  parameter logic [7:0]  DMG  = 8'd1
) (
`ifdef TICK_OVERRUN_CNT_EN
  output logic [7:0]        overrun_cnt,
`endif
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  output logic              busy,
  output logic              tick_done,
  output logic              overrun,
  output logic              bf_start,
  output logic              bf_ack,
  input  logic              bf_done,
  input  logic [LOC_W-1:0]  bf_friendly_front,
  input  logic [LOC_W-1:0]  bf_enemy_front,
  input  logic [4:0]        bf_unit_sel,
  input  logic [4:0]        bf_enemy_sel,
  output logic              dmg_unit_we,
  output logic              dmg_enemy_we,
  output logic [IDX_W-1:0]  dmg_unit_idx,
  output logic [IDX_W-1:0]  dmg_enemy_idx,
  output logic [7:0]        dmg_amount,
  output logic              mv_side,
  output logic [IDX_W-1:0]  mv_idx,
  input  logic [LOC_W-1:0]  mv_loc_in,
  input  logic [TYPE_W-1:0] mv_type_in,
  output logic              mv_we,
  output logic [LOC_W-1:0]  mv_loc_out
);

  localparam int unsigned C_W = $clog2(2 * N_SLOTS);

  state_e             state_q;
  logic [C_W-1:0]     c_q;
  logic [LOC_W-1:0]   ff_q;
  logic [LOC_W-1:0]   ef_q;
  logic [4:0]         us_q;
  logic [4:0]         es_q;
  logic               busy_q;
  logic               tick_done_q;
  logic               overrun_q;
  logic               bf_start_q;
  logic               bf_ack_q;
  logic               dmg_unit_we_q;
  logic               dmg_enemy_we_q;
  logic [IDX_W-1:0]   dmg_unit_idx_q;
  logic [IDX_W-1:0]   dmg_enemy_idx_q;

  logic               lane_we;
  logic [LOC_W-1:0]   lane_loc;
  logic               in_move;

  // Pulse outputs are set on the transition into their state so they are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      c_q             <= '0;
      ff_q            <= '0;
      ef_q            <= '0;
      us_q            <= '0;
      es_q            <= '0;
      busy_q          <= 1'b0;
      tick_done_q     <= 1'b0;
      overrun_q       <= 1'b0;
      bf_start_q      <= 1'b0;
      bf_ack_q        <= 1'b0;
      dmg_unit_we_q   <= 1'b0;
      dmg_enemy_we_q  <= 1'b0;
      dmg_unit_idx_q  <= '0;
      dmg_enemy_idx_q <= '0;
    end else begin
      bf_start_q      <= 1'b0;
      bf_ack_q        <= 1'b0;
      tick_done_q     <= 1'b0;
      dmg_unit_we_q   <= 1'b0;
      dmg_enemy_we_q  <= 1'b0;
      dmg_unit_idx_q  <= '0;
      dmg_enemy_idx_q <= '0;
      overrun_q       <= tick && (state_q != IDLE);
      unique case (state_q)
        IDLE: begin
          if (tick) begin
            state_q    <= BF_START;
            bf_start_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        BF_START: state_q <= BF_WAIT;
        BF_WAIT: begin
          if (bf_done) begin
            ff_q     <= bf_friendly_front;
            ef_q     <= bf_enemy_front;
            us_q     <= bf_unit_sel;
            es_q     <= bf_enemy_sel;
            state_q  <= BF_ACK;
            bf_ack_q <= 1'b1;
          end
        end
        BF_ACK: begin
          state_q         <= DAMAGE;
          dmg_unit_we_q   <= ~us_q[SEL_NONE_BIT];
          dmg_enemy_we_q  <= ~es_q[SEL_NONE_BIT];
          dmg_unit_idx_q  <= us_q[IDX_W-1:0];
          dmg_enemy_idx_q <= es_q[IDX_W-1:0];
        end
        DAMAGE: begin
          state_q <= MOVE;
          c_q     <= '0;
        end
        MOVE: begin
          c_q <= c_q + 1'b1;
          if (c_q == '1) begin
            state_q     <= DONE;
            tick_done_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef TICK_OVERRUN_CNT_EN
  logic [7:0] ovr_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_cnt_q <= '0;
    end else if (overrun_q && (ovr_cnt_q != '1)) begin
      ovr_cnt_q <= ovr_cnt_q + 8'd1;
    end
  end

  assign overrun_cnt = ovr_cnt_q;
`endif

  assign in_move = (state_q == MOVE);

  // Enemy slots block against the friendly front and vice versa.
  lane_step #(
    .STEP(STEP)
  ) u_lane_step (
    .side_i    (c_q[C_W-1]),
    .loc_i     (mv_loc_in),
    .type_i    (mv_type_in),
    .front_i   (c_q[C_W-1] ? ff_q : ef_q),
    .we_o      (lane_we),
    .new_loc_o (lane_loc)
  );

  assign busy          = busy_q;
  assign tick_done     = tick_done_q;
  assign overrun       = overrun_q;
  assign bf_start      = bf_start_q;
  assign bf_ack        = bf_ack_q;
  assign dmg_unit_we   = dmg_unit_we_q;
  assign dmg_enemy_we  = dmg_enemy_we_q;
  assign dmg_unit_idx  = dmg_unit_idx_q;
  assign dmg_enemy_idx = dmg_enemy_idx_q;
  assign dmg_amount    = DMG;
  assign mv_side       = c_q[C_W-1];
  assign mv_idx        = c_q[IDX_W-1:0];
  assign mv_we         = in_move & lane_we;
  assign mv_loc_out    = in_move ? lane_loc : '0;

endmodule

// File: tb/tb_battle_tick_sequencer.sv
// Scoreboard bench for battle_tick_sequencer; covers TICK_OVERRUN_CNT_EN when defined.
module tb_battle_tick_sequencer;

  localparam int unsigned STEP = 1;
  localparam logic [7:0]  DMG  = 8'd37;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       busy, tick_done, overrun, bf_start, bf_ack;
  logic       bf_done;
  logic [8:0] bf_friendly_front, bf_enemy_front;
  logic [4:0] bf_unit_sel, bf_enemy_sel;
  logic       dmg_unit_we, dmg_enemy_we;
  logic [3:0] dmg_unit_idx, dmg_enemy_idx;
  logic [7:0] dmg_amount;
  logic       mv_side;
  logic [3:0] mv_idx;
  logic [8:0] mv_loc_in;
  logic [1:0] mv_type_in;
  logic       mv_we;
  logic [8:0] mv_loc_out;
`ifdef TICK_OVERRUN_CNT_EN
  logic [7:0] overrun_cnt;
`endif

  logic [8:0] loc_m [2][16];
  logic [1:0] typ_m [2][16];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_start = 0, n_ack = 0, n_ovr = 0, n_done = 0;

  logic [13:0] mv_q [$];
  logic [17:0] dmg_q [$];

  battle_tick_sequencer #(
    .STEP(STEP),
    .DMG (DMG)
  ) dut (
`ifdef TICK_OVERRUN_CNT_EN
    .overrun_cnt      (overrun_cnt),
`endif
    .clk              (clk),
    .rst              (rst),
    .tick             (tick),
    .busy             (busy),
    .tick_done        (tick_done),
    .overrun          (overrun),
    .bf_start         (bf_start),
    .bf_ack           (bf_ack),
    .bf_done          (bf_done),
    .bf_friendly_front(bf_friendly_front),
    .bf_enemy_front   (bf_enemy_front),
    .bf_unit_sel      (bf_unit_sel),
    .bf_enemy_sel     (bf_enemy_sel),
    .dmg_unit_we      (dmg_unit_we),
    .dmg_enemy_we     (dmg_enemy_we),
    .dmg_unit_idx     (dmg_unit_idx),
    .dmg_enemy_idx    (dmg_enemy_idx),
    .dmg_amount       (dmg_amount),
    .mv_side          (mv_side),
    .mv_idx           (mv_idx),
    .mv_loc_in        (mv_loc_in),
    .mv_type_in       (mv_type_in),
    .mv_we            (mv_we),
    .mv_loc_out       (mv_loc_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mv_loc_in  = loc_m[mv_side][mv_idx];
  assign mv_type_in = typ_m[mv_side][mv_idx];

  function automatic logic [29:0] outs();
    return {busy, tick_done, overrun, bf_start, bf_ack, dmg_unit_we, dmg_enemy_we,
            dmg_unit_idx, dmg_enemy_idx, mv_side, mv_idx, mv_we, mv_loc_out};
  endfunction

  // Scoreboard side: every write or damage strobe must match the oldest expectation.
  always @(negedge clk) begin
    logic [13:0] mexp;
    logic [17:0] dexp;
    if (bf_start)  n_start++;
    if (bf_ack)    n_ack++;
    if (overrun)   n_ovr++;
    if (tick_done) n_done++;
    if (mv_we) begin
      total++;
      if (mv_q.size() == 0) begin
        bad++;
        $display("FAIL mv_write unexpected: got side=%0d idx=%0d loc=%0d, want no write",
                 mv_side, mv_idx, mv_loc_out);
      end else begin
        mexp = mv_q.pop_front();
        if ({mv_side, mv_idx, mv_loc_out} !== mexp) begin
          bad++;
          $display("FAIL mv_write: got side=%0d idx=%0d loc=%0d, want side=%0d idx=%0d loc=%0d",
                   mv_side, mv_idx, mv_loc_out, mexp[13], mexp[12:9], mexp[8:0]);
        end
      end
    end
    if (dmg_unit_we || dmg_enemy_we) begin
      total++;
      if (dmg_q.size() == 0) begin
        bad++;
        $display("FAIL dmg_strobe unexpected: got uwe=%0d ewe=%0d, want none",
                 dmg_unit_we, dmg_enemy_we);
      end else begin
        dexp = dmg_q.pop_front();
        if ({dmg_unit_we, dmg_unit_idx, dmg_enemy_we, dmg_enemy_idx, dmg_amount} !== dexp) begin
          bad++;
          $display("FAIL dmg_strobe: got %h, want %h",
                   {dmg_unit_we, dmg_unit_idx, dmg_enemy_we, dmg_enemy_idx, dmg_amount}, dexp);
        end
      end
    end
  end

  task automatic clear_slots();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 16; i++) begin
        loc_m[s][i] = 9'd0;
        typ_m[s][i] = 2'd0;
      end
  endtask

  task automatic push_expect(input logic [8:0] ff, input logic [8:0] ef,
                             input logic [4:0] us, input logic [4:0] es, input int last_c);
    for (int c = 0; c < 32; c++) begin
      int side, idx, l, t, n;
      side = c / 16;
      idx  = c % 16;
      l    = int'(loc_m[side][idx]);
      t    = int'(typ_m[side][idx]);
      if (c <= last_c && t != 0) begin
        if (side == 0) begin
          n = l - int'(STEP);
          if (l >= int'(STEP) && n > int'(ef)) mv_q.push_back({1'b0, 4'(idx), 9'(n)});
        end else begin
          n = l + int'(STEP);
          if (n <= 511 && n < int'(ff)) mv_q.push_back({1'b1, 4'(idx), 9'(n)});
        end
      end
    end
    if (!us[4] || !es[4]) dmg_q.push_back({~us[4], us[3:0], ~es[4], es[3:0], DMG});
  endtask

  // Drives one tick. abort_c < 0 resets in BF_WAIT; 0..31 resets at that MOVE slot.
  task automatic run_tick(input logic [8:0] ff, input logic [8:0] ef,
                          input logic [4:0] us, input logic [4:0] es,
                          input int wait_cyc, input int abort_c, input bit do_ovr,
                          output int lat);
    int t0;
    lat = -1;
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0; t0 = cyc;
    total++;
    if ({bf_start, busy} !== 2'b11) begin
      bad++; $display("FAIL start_pulse: got start/busy=%b, want 11", {bf_start, busy});
    end
    @(negedge clk);
    total++;
    if (bf_start !== 1'b0) begin
      bad++; $display("FAIL start_width: got bf_start=%b in BF_WAIT, want 0", bf_start);
    end
    if (abort_c < 0) begin
      rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      total++;
      if (outs() !== '0) begin
        bad++; $display("FAIL rst_bf_wait: got outputs=%h, want 0", outs());
      end
      return;
    end
    repeat (wait_cyc) @(negedge clk);
    bf_friendly_front = ff; bf_enemy_front = ef;
    bf_unit_sel = us; bf_enemy_sel = es; bf_done = 1'b1;
    push_expect(ff, ef, us, es, (abort_c < 32) ? abort_c : 31);
    @(negedge clk);
    bf_done = 1'b0;
    bf_friendly_front = ~ff; bf_enemy_front = ~ef; bf_unit_sel = ~us; bf_enemy_sel = ~es;
    total++;
    if (bf_ack !== 1'b1) begin
      bad++; $display("FAIL ack_pulse: got bf_ack=%b, want 1", bf_ack);
    end
    @(negedge clk);
    total++;
    if (bf_ack !== 1'b0) begin
      bad++; $display("FAIL ack_width: got bf_ack=%b in DAMAGE, want 0", bf_ack);
    end
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      tick = do_ovr && (c == 5 || c == 10 || c == 15);
      if (c == abort_c) begin
        rst = 1'b1;
        @(negedge clk); rst = 1'b0; tick = 1'b0;
        total++;
        if (outs() !== '0) begin
          bad++; $display("FAIL rst_move: got outputs=%h, want 0", outs());
        end
        return;
      end
    end
    tick = 1'b0;
    @(negedge clk);
    total++;
    if (tick_done !== 1'b1) begin
      bad++; $display("FAIL tick_done: got %b at expected cycle, want 1", tick_done);
    end
    lat = cyc + 1 - t0;
    @(negedge clk);
    total++;
    if ({busy, tick_done} !== 2'b00) begin
      bad++; $display("FAIL back_idle: got busy/done=%b, want 00", {busy, tick_done});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({outs(), dmg_amount} !== {30'd0, DMG}) begin
      bad++; $display("FAIL reset_state: got %h, want %h", {outs(), dmg_amount}, {30'd0, DMG});
    end
`ifdef TICK_OVERRUN_CNT_EN
    total++;
    if (overrun_cnt !== 8'd0) begin
      bad++; $display("FAIL reset_ovr_cnt: got %0d, want 0", overrun_cnt);
    end
`endif
  endtask

  task automatic load_main();
    clear_slots();
    loc_m[0][14] = 9'd480; typ_m[0][14] = 2'd1;
    loc_m[0][3]  = 9'd200; typ_m[0][3]  = 2'd2;
    loc_m[1][1]  = 9'd32;  typ_m[1][1]  = 2'd1;
    loc_m[1][7]  = 9'd473; typ_m[1][7]  = 2'd3;
    loc_m[1][8]  = 9'd472; typ_m[1][8]  = 2'd1;
  endtask

  task automatic test_main_move();
    int lat, s0, a0;
    load_main();
    s0 = n_start; a0 = n_ack;
    run_tick(9'd474, 9'd39, 5'd14, 5'd1, 0, 32, 1'b0, lat);
    total++;
    if (lat != 37) begin
      bad++; $display("FAIL latency_min: got %0d, want 37", lat);
    end
    total++;
    if (mv_q.size() != 0 || dmg_q.size() != 0) begin
      bad++; $display("FAIL main_missing: got left mv=%0d dmg=%0d, want 0 0", mv_q.size(), dmg_q.size());
    end
    total++;
    if (n_start - s0 != 1 || n_ack - a0 != 1) begin
      bad++; $display("FAIL pulse_count: got start=%0d ack=%0d, want 1 1", n_start - s0, n_ack - a0);
    end
  endtask

  task automatic test_blocking();
    int lat;
    clear_slots();
    loc_m[0][2] = 9'd40;  typ_m[0][2] = 2'd1;
    loc_m[0][5] = 9'd0;   typ_m[0][5] = 2'd1;
    loc_m[0][6] = 9'd41;  typ_m[0][6] = 2'd1;
    loc_m[0][9] = 9'd300; typ_m[0][9] = 2'd0;
    loc_m[1][0] = 9'd511; typ_m[1][0] = 2'd1;
    loc_m[1][4] = 9'd510; typ_m[1][4] = 2'd1;
    loc_m[1][9] = 9'd100; typ_m[1][9] = 2'd2;
    loc_m[1][12] = 9'd299; typ_m[1][12] = 2'd1;
    run_tick(9'd300, 9'd39, 5'd16, 5'd16, 1, 32, 1'b0, lat);
    total++;
    if (lat != 38) begin
      bad++; $display("FAIL latency_wait1: got %0d, want 38", lat);
    end
    total++;
    if (mv_q.size() != 0 || dmg_q.size() != 0) begin
      bad++; $display("FAIL block_missing: got left mv=%0d dmg=%0d, want 0 0", mv_q.size(), dmg_q.size());
    end
  endtask

  task automatic test_empty();
    int lat;
    clear_slots();
    for (int i = 0; i < 16; i++) begin
      loc_m[0][i] = 9'(100 + i);
      loc_m[1][i] = 9'(20 + i);
    end
    run_tick(9'd400, 9'd10, 5'd31, 5'd3, 4, 32, 1'b0, lat);
    total++;
    if (lat != 41) begin
      bad++; $display("FAIL latency_wait4: got %0d, want 41", lat);
    end
    total++;
    if (dmg_q.size() != 0) begin
      bad++; $display("FAIL empty_dmg_missing: got left %0d, want 0", dmg_q.size());
    end
  endtask

  task automatic test_overrun();
    int lat, s0, o0;
    load_main();
    s0 = n_start; o0 = n_ovr;
    run_tick(9'd474, 9'd39, 5'd2, 5'd20, 0, 32, 1'b1, lat);
    total++;
    if (n_ovr - o0 != 3 || n_start - s0 != 1) begin
      bad++; $display("FAIL overrun_pulses: got ovr=%0d start=%0d, want 3 1", n_ovr - o0, n_start - s0);
    end
    total++;
    if (lat != 37 || mv_q.size() != 0) begin
      bad++; $display("FAIL overrun_seq: got lat=%0d left=%0d, want 37 0", lat, mv_q.size());
    end
`ifdef TICK_OVERRUN_CNT_EN
    total++;
    if (overrun_cnt !== 8'd3) begin
      bad++; $display("FAIL overrun_cnt: got %0d, want 3", overrun_cnt);
    end
`endif
  endtask

  task automatic test_reset_abort();
    int lat, s0;
    clear_slots();
    for (int i = 0; i < 16; i++) begin
      loc_m[0][i] = 9'd256; typ_m[0][i] = 2'd1;
      loc_m[1][i] = 9'd256; typ_m[1][i] = 2'd3;
    end
    run_tick(9'd511, 9'd0, 5'd16, 5'd16, 0, -1, 1'b0, lat);
    run_tick(9'd511, 9'd0, 5'd16, 5'd16, 0, 10, 1'b0, lat);
    s0 = n_start;
    repeat (40) @(negedge clk);
    total++;
    if (n_start != s0 || busy !== 1'b0 || mv_q.size() != 0) begin
      bad++; $display("FAIL rst_quiet: got starts=%0d busy=%b left=%0d, want 0 0 0",
                      n_start - s0, busy, mv_q.size());
    end
`ifdef TICK_OVERRUN_CNT_EN
    total++;
    if (overrun_cnt !== 8'd0) begin
      bad++; $display("FAIL rst_ovr_cnt: got %0d, want 0", overrun_cnt);
    end
`endif
  endtask

  task automatic test_after_reset();
    int lat;
    run_tick(9'd511, 9'd0, 5'd0, 5'd15, 0, 32, 1'b0, lat);
    total++;
    if (lat != 37 || mv_q.size() != 0 || dmg_q.size() != 0) begin
      bad++; $display("FAIL after_rst: got lat=%0d left mv=%0d dmg=%0d, want 37 0 0",
                      lat, mv_q.size(), dmg_q.size());
    end
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; bf_done = 1'b0;
    bf_friendly_front = '0; bf_enemy_front = '0; bf_unit_sel = '0; bf_enemy_sel = '0;
    clear_slots();
    test_reset();
    test_main_move();
    test_blocking();
    test_empty();
    test_overrun();
    test_reset_abort();
    test_after_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
